// File: rtl/am29705_ctl.sv
// Command sequencer for an Am29705 16x4 two-port register file: turns read, write,
// write-then-read and clear commands into setup/strobe/hold pin sequences.
module am29705_ctl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_d,
  input  logic       cmd_zero_a,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_ya,
  output logic [3:0] rsp_yb,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] d,
  output logic       we1_,
  output logic       we2_,
  output logic       le_,
  output logic       alo_,
  output logic       oea_,
  output logic       oeb_,
  input  logic [3:0] ya,
  input  logic [3:0] yb
);

  typedef enum logic [3:0] {
    IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RSAMPLE, RESP, CSETUP, CSTROBE, CHOLD
  } state_t;

  state_t     st;
  logic [3:0] cnt;
  logic       rd_after;
  logic       zq;

  // Every pin is a register updated on the transition into the state that needs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= 4'd0;
      rd_after  <= 1'b0;
      zq        <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ya    <= 4'd0;
      rsp_yb    <= 4'd0;
      a         <= 4'd0;
      b         <= 4'd0;
      d         <= 4'd0;
      we1_      <= 1'b1;
      we2_      <= 1'b1;
      le_       <= 1'b1;
      alo_      <= 1'b1;
      oea_      <= 1'b1;
      oeb_      <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            zq        <= cmd_zero_a;
            case (cmd_op)
              2'b00: begin
                st   <= RSETUP;
                a    <= cmd_a;
                b    <= cmd_b;
                oea_ <= 1'b0;
                oeb_ <= 1'b0;
                alo_ <= ~cmd_zero_a;
              end
              2'b01, 2'b10: begin
                st       <= WSETUP;
                a        <= cmd_a;
                b        <= cmd_b;
                d        <= cmd_d;
                rd_after <= cmd_op[1];
              end
              default: begin
                st  <= CSETUP;
                cnt <= 4'd0;
                b   <= 4'd0;
                d   <= 4'd0;
              end
            endcase
          end
        end
        WSETUP: begin
          st   <= WSTROBE;
          we1_ <= 1'b0;
          we2_ <= 1'b0;
        end
        WSTROBE: begin
          st   <= WHOLD;
          we1_ <= 1'b1;
          we2_ <= 1'b1;
        end
        WHOLD: begin
          if (rd_after) begin
            st   <= RSETUP;
            oea_ <= 1'b0;
            oeb_ <= 1'b0;
            alo_ <= ~zq;
          end else begin
            st        <= RESP;
            rsp_valid <= 1'b1;
            rsp_ya    <= 4'd0;
            rsp_yb    <= 4'd0;
          end
        end
        RSETUP: st <= RSAMPLE;
        RSAMPLE: begin
          // Capture on the same edge that closes the chip latch.
          st        <= RESP;
          rsp_ya    <= ya;
          rsp_yb    <= yb;
          le_       <= 1'b0;
          rsp_valid <= 1'b1;
        end
        CSETUP: begin
          st   <= CSTROBE;
          we1_ <= 1'b0;
          we2_ <= 1'b0;
        end
        CSTROBE: begin
          st   <= CHOLD;
          we1_ <= 1'b1;
          we2_ <= 1'b1;
        end
        CHOLD: begin
          if (cnt == 4'd15) begin
            st        <= RESP;
            cnt       <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_ya    <= 4'd0;
            rsp_yb    <= 4'd0;
          end else begin
            st  <= CSETUP;
            cnt <= cnt + 4'd1;
            b   <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            st        <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            a         <= 4'd0;
            b         <= 4'd0;
            d         <= 4'd0;
            le_       <= 1'b1;
            alo_      <= 1'b1;
            oea_      <= 1'b1;
            oeb_      <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am29705_ctl.sv
// Bench for am29705_ctl: behavioural 29705 chip model on the pins, a table of
// directed commands, hand sequences for backpressure/reset, then random commands.
module tb_am29705_ctl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_a = 4'd0, cmd_b = 4'd0, cmd_d = 4'd0;
  logic       cmd_zero_a = 1'b0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [3:0] rsp_ya, rsp_yb, a, b, d, ya, yb;
  logic       we1_, we2_, le_, alo_, oea_, oeb_;

  am29705_ctl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_zero_a(cmd_zero_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ya(rsp_ya), .rsp_yb(rsp_yb),
    .a(a), .b(b), .d(d), .we1_(we1_), .we2_(we2_), .le_(le_), .alo_(alo_),
    .oea_(oea_), .oeb_(oeb_), .ya(ya), .yb(yb));

  always #5 clk = ~clk;

  // Chip model: RAM written when both write enables are low at a clock edge.
  logic [3:0] chip [16];
  always @(posedge clk) if (!we1_ && !we2_) chip[b] <= d;
  assign ya = (oea_ || !alo_) ? 4'h0 : chip[a];
  assign yb = oeb_ ? 4'h0 : chip[b];

  // Reference contents of the register file, maintained per command.
  logic [3:0] mem [16];
  int tests = 0, fails = 0;
  logic [3:0] pb[$], pd[$];
  logic       pw[$];

  typedef struct {
    logic [1:0] op;
    logic [3:0] a, b, d;
    logic       z;
    int         hold;
    logic [3:0] eya, eyb;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [3:0] ca, cb, cd, input logic z,
                       output logic [3:0] eya, output logic [3:0] eyb);
    eya = 4'd0;
    eyb = 4'd0;
    if (op == 2'd3) for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    if (op == 2'd1 || op == 2'd2) mem[cb] = cd;
    if (op == 2'd0 || op == 2'd2) begin
      eya = z ? 4'd0 : mem[ca];
      eyb = mem[cb];
    end
  endtask

  task automatic apply(input logic [1:0] op, input logic [3:0] ca, cb, cd, input logic z,
                       input int hold, input logic [3:0] eya, eyb, input string tag);
    int g, lat, elat, np;
    logic alo_rd;
    bit alo_got;
    pb.delete(); pd.delete(); pw.delete();
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = ca; cmd_b = cb; cmd_d = cd; cmd_zero_a = z;
    rsp_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; alo_got = 0; alo_rd = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (!we1_ || !we2_) begin pb.push_back(b); pd.push_back(d); pw.push_back(we1_ | we2_); end
      if (!oea_ && !alo_got) begin alo_rd = alo_; alo_got = 1; end
      @(negedge clk);
      lat++;
    end
    elat = (op == 2'd0) ? 2 : (op == 2'd1) ? 3 : (op == 2'd2) ? 5 : 48;
    chk({tag, " latency"}, lat, elat);
    chk({tag, " rsp_ya"}, rsp_ya, eya);
    chk({tag, " rsp_yb"}, rsp_yb, eyb);
    chk({tag, " le_ in RESP"}, le_, (op == 2'd0 || op == 2'd2) ? 0 : 1);
    if (op == 2'd0 || op == 2'd2) chk({tag, " alo_"}, {alo_got, alo_rd}, {1'b1, ~z});
    np = (op == 2'd3) ? 16 : (op == 2'd0) ? 0 : 1;
    chk({tag, " we pulses"}, pb.size(), np);
    for (int i = 0; i < pb.size() && i < np; i++) begin
      chk({tag, " pulse b"}, pb[i], (op == 2'd3) ? i : cb);
      chk({tag, " pulse d"}, pd[i], (op == 2'd3) ? 0 : cd);
      chk({tag, " pulse we2_"}, pw[i], 0);
    end
    for (int i = 0; i < hold; i++) begin
      chk({tag, " held rsp_valid"}, rsp_valid, 1);
      chk({tag, " held cmd_ready"}, cmd_ready, 0);
      chk({tag, " held rsp_ya"}, rsp_ya, eya);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " post rsp_valid"}, rsp_valid, 0);
    chk({tag, " post idle pins"}, {cmd_ready, le_, alo_, oea_, oeb_, we1_}, 6'b111111);
  endtask

  initial begin
    logic [3:0] eya, eyb, ra, rb;
    logic [1:0] op;
    int g, k;

    tbl[0] = '{2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 0, 4'h0, 4'h0};
    tbl[1] = '{2'd1, 4'd0, 4'd5, 4'hA, 1'b0, 0, 4'h0, 4'h0};
    tbl[2] = '{2'd0, 4'd5, 4'd5, 4'd0, 1'b0, 0, 4'hA, 4'hA};
    tbl[3] = '{2'd0, 4'd0, 4'd15, 4'd0, 1'b0, 1, 4'h0, 4'h0};
    tbl[4] = '{2'd1, 4'd0, 4'd3, 4'hC, 1'b0, 0, 4'h0, 4'h0};
    tbl[5] = '{2'd2, 4'd3, 4'd9, 4'h6, 1'b0, 0, 4'hC, 4'h6};
    tbl[6] = '{2'd1, 4'd0, 4'd7, 4'hF, 1'b0, 2, 4'h0, 4'h0};
    tbl[7] = '{2'd0, 4'd7, 4'd9, 4'd0, 1'b1, 5, 4'h0, 4'h6};

    #12;
    chk("reset handshake", {cmd_ready, rsp_valid, rsp_ya, rsp_yb}, {1'b1, 1'b0, 8'h00});
    chk("reset abd", {a, b, d}, 12'h000);
    chk("reset ctl pins", {we1_, we2_, le_, alo_, oea_, oeb_}, 6'b111111);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      model(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].z, eya, eyb);
      apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].z, tbl[i].hold,
            tbl[i].eya, tbl[i].eyb, $sformatf("vec%0d", i));
    end

    // Queued command waits through a stalled response, then is taken one cycle later.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 4'd5; cmd_b = 4'd5; cmd_zero_a = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_a = 4'd9; cmd_b = 4'd3;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    chk("queue first latency", g, 2);
    for (int i = 0; i < 5; i++) begin
      chk("queue stall", {rsp_valid, cmd_ready, le_, rsp_ya, rsp_yb}, {3'b100, mem[5], mem[5]});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("queue after handshake", {rsp_valid, cmd_ready}, 2'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("queue accepted", {cmd_ready, oea_, a, b}, {2'b00, 4'd9, 4'd3});
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    chk("queue second latency", g, 2);
    chk("queue second data", {rsp_ya, rsp_yb}, {mem[9], mem[3]});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Asynchronous reset while the write strobe is active.
    g = 0;
    while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_b = 4'd2; cmd_d = 4'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid-write we_ low", {we1_, we2_, b, d}, {2'b00, 4'd2, 4'h9});
    rst = 1'b1;
    #1;
    chk("async reset we_", {we1_, we2_}, 2'b11);
    chk("async reset handshake", {cmd_ready, rsp_valid}, 2'b10);
    chk("async reset pins", {a, b, d, le_, alo_, oea_, oeb_}, {12'h000, 4'b1111});
    @(negedge clk);
    rst = 1'b0;
    model(2'd3, 4'd0, 4'd0, 4'd0, 1'b0, eya, eyb);
    apply(2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 0, eya, eyb, "clear after reset");

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      op = (k < 4) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      cmd_d = 4'($urandom_range(0, 15));
      cmd_zero_a = ($urandom_range(0, 3) == 0);
      model(op, ra, rb, cmd_d, cmd_zero_a, eya, eyb);
      apply(op, ra, rb, cmd_d, cmd_zero_a, $urandom_range(0, 2), eya, eyb,
            $sformatf("rand%0d op%0d", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/am29705_ctl.md
# am29705_ctl

Synchronous command sequencer that drives an Am29705 16x4 two-port register file. It accepts read, write, write-then-read and clear commands over a valid/ready interface. For each command it generates the chip's address, data, write-enable, latch-enable, force-zero and output-enable pins with explicit setup, strobe and hold cycles, then returns the captured YA/YB data on a response handshake. It sits between microcode control logic and one or more cascaded 29705 slices.

## Interface

Parameters:
- none; the data width is fixed at 4 to match one 29705 slice.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller idle, command accepted when both valid and ready are high.
- cmd_op  input  2  00 read, 01 write, 10 write-then-read, 11 clear-all.
- cmd_a  input  4  A read address.
- cmd_b  input  4  B read/write address.
- cmd_d  input  4  write data.
- cmd_zero_a  input  1  force YA=0 (drives alo_ low) during the read phase.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_ya  output  4  captured YA (0000 for write/clear).
- rsp_yb  output  4  captured YB (0000 for write/clear).
- a, b, d  output  4 each  to chip A address, B address, D data.
- we1_, we2_, le_, alo_, oea_, oeb_  output  1 each  to chip, active-low.
- ya, yb  input  4 each  from chip outputs.

## Operation

- Command fields are registered at acceptance. Chip pins are driven only from registers, with no combinational path from cmd_* to the pins.
- Idle and reset pin values:
  - a=b=d=0000.
  - we1_=we2_=1, le_=1 (transparent), alo_=1, oea_=oeb_=1 (Y outputs tri-stated).
- Idle and reset handshake values: cmd_ready=1, rsp_valid=0, rsp_ya=rsp_yb=0000.
- States: IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RSAMPLE, RESP, CSETUP, CSTROBE, CHOLD.
- Write (01): IDLE→WSETUP→WSTROBE→WHOLD→RESP.
  - b=cmd_b and d=cmd_d in all three write states.
  - we1_=we2_=0 only in WSTROBE.
  - oea_=oeb_=1 throughout.
- Read (00): IDLE→RSETUP→RSAMPLE→RESP.
  - a=cmd_a, b=cmd_b, le_=1, oea_=oeb_=0, alo_=~cmd_zero_a.
  - On the edge leaving RSAMPLE, ya/yb are captured into rsp_ya/rsp_yb.
  - le_=0 in RESP, so the chip latches the read data; alo_ keeps its read-phase value in RESP.
- Write-then-read (10): write sequence (WSETUP→WSTROBE→WHOLD), then RSETUP→RSAMPLE→RESP.
  - WHOLD proceeds to RSETUP instead of RESP.
  - Reading cmd_b returns the newly written value.
- Clear (11): a 4-bit counter cnt starts at 0.
  - Each address goes through CSETUP→CSTROBE→CHOLD with b=cnt and d=0000; we_ is low only in CSTROBE.
  - CHOLD with cnt=15 goes to RESP. Otherwise cnt increments and the sequence returns to CSETUP.
  - cnt wraps 15→0 on completion.
- RESP: rsp_valid=1 and cmd_ready=0.
  - On rsp_valid&&rsp_ready the controller returns to IDLE and restores idle pin values (le_=1, alo_=1, oe_=1).
  - rsp_ya/rsp_yb hold their values until the next capture or clear.
- Write/clear responses carry rsp_ya=rsp_yb=0000.
- cmd_ready is high only in IDLE. Commands presented in other states wait; they are not dropped.

## Timing

- Let E0 be the accepting edge.
- Read: RSETUP after E0, RSAMPLE after E1, capture at E2, rsp_valid high after E2 (2-cycle latency).
- Write: we_ low for exactly one cycle (between E1 and E2), rsp_valid after E3.
  - Address and data are stable one cycle before and one cycle after the strobe.
- Write-then-read: strobe between E1 and E2, capture at E5, rsp_valid after E5.
- Clear: 48 cycles of strobing, rsp_valid after E48.
- Back-to-back: the earliest next acceptance is on the same edge that completes the RESP handshake +1. The controller spends at least one IDLE cycle between commands.
- rsp_ready held high before rsp_valid: the handshake completes on the first edge where rsp_valid is high.
- Reset asynchronous, at any point including mid-strobe:
  - We_ deasserts immediately.
  - All outputs take their idle values without waiting for clk.
  - A pending response is discarded and cnt is cleared.
- Reset release: the first command can be accepted on the first rising edge with rst low.

## Test plan

- Reset, then write(b=5, d=1010), then read(a=5, b=5) → we_ low exactly one cycle with b=0101 and d=1010; rsp_ya=rsp_yb=1010 two cycles after acceptance.
- Clear, then read(a=0, b=15) → exactly 16 we_ pulses at b=0..15 with d=0000; rsp_valid after 48 cycles; read returns 0000/0000.
- Write-then-read(a=3, b=9, d=0110) after write(3, 1100) → rsp_ya=1100, rsp_yb=0110, rsp_valid after E5.
- Read with cmd_zero_a=1, a=7 holding 1111 → alo_=0, rsp_ya=0000, rsp_yb equals RAM[b].
- rsp_ready held low for 5 cycles → rsp_valid, le_=0 and data are stable; cmd_ready stays 0; a queued command is accepted one cycle after the handshake.
- rst asserted between E1 and E2 of a write (we_ low) → we_=1, cmd_ready=1 and rsp_valid=0 asynchronously; the target location's contents are not checked.
